// File: rtl/sbox_cipher_pkg.sv
// -----------------------------------------------------------------------------
// sbox_cipher_pkg
// Shared types and defaults for the S-box keystream channel arbiter.
//   DEFAULT_N_CH : default number of byte-stream channels
//   byte_t       : 8-bit data byte
//   ctx_state_t  : per-channel key context state (UNKEYED / KEYED)
// -----------------------------------------------------------------------------
package sbox_cipher_pkg;

  localparam int DEFAULT_N_CH = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    UNKEYED = 1'b0,
    KEYED   = 1'b1
  } ctx_state_t;

endpackage : sbox_cipher_pkg

// File: rtl/aes_sbox_lut.sv
// -----------------------------------------------------------------------------
// aes_sbox_lut
// Combinational AES forward S-box, 256-entry lookup.
// Ports:
//   i_data : 8-bit S-box input
//   o_data : 8-bit substituted output
// -----------------------------------------------------------------------------
module aes_sbox_lut
  import sbox_cipher_pkg::*;
(
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_data = SBOX[i_data];

endmodule : aes_sbox_lut

// File: rtl/sbox_cipher_channel_arbiter.sv
// -----------------------------------------------------------------------------
// sbox_cipher_channel_arbiter
// Shares one AES S-box keystream datapath among N_CH byte-stream channels.
// Each channel owns a key/counter context; every accepted byte leaves as
// sbox(ctr) ^ char and bumps that channel's counter. A round-robin arbiter
// feeds a 2-stage pipeline (A: capture, B: transform) into one sink that may
// stall.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   key_load   : per-channel key-load strobe (loads key_in into ctr, sets KEYED)
//   key_in     : key byte
//   req_valid  : per-channel byte available
//   req_char   : packed per-channel bytes, channel i at [8*i +: 8]
//   req_ready  : one-hot grant
//   dout_valid : output byte valid
//   dout_char  : transformed byte
//   dout_chan  : channel id of dout_char
//   dout_ready : sink ready
// -----------------------------------------------------------------------------
module sbox_cipher_channel_arbiter
  import sbox_cipher_pkg::*;
#(
  parameter int N_CH   = DEFAULT_N_CH,
  parameter int CHAN_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   key_load,
  input  logic [7:0]        key_in,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [8*N_CH-1:0] req_char,
  output logic [N_CH-1:0]   req_ready,
  output logic              dout_valid,
  output logic [7:0]        dout_char,
  output logic [CHAN_W-1:0] dout_chan,
  input  logic              dout_ready
);

  // Per-channel contexts
  ctx_state_t        r_state     [N_CH];
  ctx_state_t        w_state_nxt [N_CH];
  byte_t             r_ctr       [N_CH];

  // Arbitration
  logic [CHAN_W-1:0] r_ptr;
  logic [N_CH-1:0]   w_elig;
  logic              w_grant_vld;
  logic [CHAN_W-1:0] w_grant_idx;
  logic              w_adv;
  logic              w_fire;
  byte_t             w_sel_char;

  // Stage A
  logic              r_a_valid;
  logic [CHAN_W-1:0] r_a_chan;
  byte_t             r_a_char;
  byte_t             r_a_ctr;

  // Stage B keystream
  byte_t             w_ks;

  // The whole pipe moves together: it advances whenever the output register
  // is empty or being drained this cycle.
  assign w_adv  = !dout_valid || dout_ready;
  assign w_fire = w_adv && w_grant_vld;

  // ---------------------------------------------------------------------------
  // Context FSM: any state -> KEYED on key_load; only reset returns UNKEYED.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a value on every path (default
    // first), otherwise the tool infers a latch to hold the old value.
    for (int i = 0; i < N_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      if (key_load[i]) begin
        w_state_nxt[i] = KEYED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= UNKEYED;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  // A channel being rekeyed this cycle is held off so its next byte is
  // guaranteed to see the new counter.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_elig[i] = req_valid[i] && (r_state[i] == KEYED) && !key_load[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search starting at r_ptr, wrapping modulo N_CH.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!w_grant_vld && w_elig[idx[CHAN_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = idx[CHAN_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_fire) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_sel_char = req_char[8*w_grant_idx +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= (w_grant_idx == CHAN_W'(N_CH - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters: a load overrides, otherwise the granted channel increments
  // (8-bit wrap). Load and grant never coincide on one channel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the context array is small and its reset value (counter 0x00) is
    // architecturally visible, so it is reset like any other register rather
    // than left as uninitialised storage.
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_ctr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (key_load[i]) begin
          r_ctr[i] <= key_in;
        end else if (w_fire && (w_grant_idx == CHAN_W'(i))) begin
          r_ctr[i] <= r_ctr[i] + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage A: capture granted byte with the counter value it must use. The
  // captured counter travels with the byte, so a later rekey cannot touch it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_chan  <= '0;
      r_a_char  <= '0;
      r_a_ctr   <= '0;
    end else if (w_adv) begin
      r_a_valid <= w_fire;
      if (w_fire) begin
        r_a_chan <= w_grant_idx;
        r_a_char <= w_sel_char;
        r_a_ctr  <= r_ctr[w_grant_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: S-box and XOR into the output register; holds while stalled.
  // ---------------------------------------------------------------------------
  aes_sbox_lut u_sbox (
    .i_data (r_a_ctr),
    .o_data (w_ks)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_char  <= '0;
      dout_chan  <= '0;
    end else if (w_adv) begin
      dout_valid <= r_a_valid;
      if (r_a_valid) begin
        dout_char <= w_ks ^ r_a_char;
        dout_chan <= r_a_chan;
      end
    end
  end

endmodule : sbox_cipher_channel_arbiter

// File: tb/tb_sbox_cipher_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sbox_cipher_channel_arbiter
// Self-checking bench: a behavioural model (S-box derived from GF(2^8)
// inversion + affine map, arbitration by plain search) is compared against
// the DUT on every negative clock edge, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_sbox_cipher_channel_arbiter;
  import sbox_cipher_pkg::*;

  localparam int N  = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    key_load;
  logic [7:0]      key_in;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_char;
  logic [N-1:0]    req_ready;
  logic            dout_valid;
  logic [7:0]      dout_char;
  logic [CW-1:0]   dout_chan;
  logic            dout_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sbox_cipher_channel_arbiter #(.N_CH(N), .CHAN_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key_in     (key_in),
    .req_valid  (req_valid),
    .req_char   (req_char),
    .req_ready  (req_ready),
    .dout_valid (dout_valid),
    .dout_char  (dout_char),
    .dout_chan  (dout_chan),
    .dout_ready (dout_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference S-box from its mathematical definition.
  // ---------------------------------------------------------------------------
  byte_t sbox_ref [256];

  function automatic byte_t gmul(input byte_t a_in, input byte_t b_in);
    byte_t a = a_in;
    byte_t b = b_in;
    byte_t p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic byte_t rotl(input byte_t v, input int n);
    return byte_t'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic byte_t sbox_math(input byte_t x);
    byte_t inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'h00 && gmul(x, byte_t'(y)) == 8'h01) inv = byte_t'(y);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: byte results are computed at acceptance and travel
  // through two "in flight" slots toward the sink.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit    v;
    byte_t c;
    int    ch;
  } item_t;

  bit         m_keyed [N];
  byte_t      m_ctr   [N];
  int         m_ptr;
  item_t      m_a;
  item_t      m_out;
  bit         m_adv;
  int         m_g;
  int         m_idx;
  logic [N-1:0] m_rr;

  int    grant_log [$];
  item_t seen      [$];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_keyed[i] = 1'b0;
        m_ctr[i]   = 8'h00;
      end
      m_ptr = 0;
      m_a   = '{1'b0, 8'h00, 0};
      m_out = '{1'b0, 8'h00, 0};
      check("rst_req_ready", req_ready, '0);
      check("rst_dout_valid", dout_valid, 1'b0);
      check("rst_dout_char", dout_char, 8'h00);
      check("rst_dout_chan", dout_chan, '0);
    end else begin
      m_adv = !m_out.v || dout_ready;
      m_g   = -1;
      for (int k = 0; k < N; k++) begin
        m_idx = (m_ptr + k) % N;
        if (m_g < 0 && req_valid[m_idx] && m_keyed[m_idx] && !key_load[m_idx]) m_g = m_idx;
      end
      m_rr = '0;
      if (m_adv && m_g >= 0) m_rr[m_g] = 1'b1;

      check("req_ready", req_ready, m_rr);
      check("dout_valid", dout_valid, m_out.v);
      if (m_out.v) begin
        check("dout_char", dout_char, m_out.c);
        check("dout_chan", dout_chan, m_out.ch);
      end

      // Logs of what the DUT actually did, for directed ordering checks.
      if (dout_valid && dout_ready) seen.push_back('{1'b1, dout_char, int'(dout_chan)});
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
      end

      if (m_adv) begin
        m_out = m_a;
        if (m_g >= 0) begin
          m_a = '{1'b1, sbox_ref[m_ctr[m_g]] ^ req_char[8*m_g +: 8], m_g};
          m_ctr[m_g] = m_ctr[m_g] + 8'd1;
          m_ptr = (m_g + 1) % N;
        end else begin
          m_a.v = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (key_load[i]) begin
          m_keyed[i] = 1'b1;
          m_ctr[i]   = key_in;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int ch, input byte_t k);
    key_load     = '0;
    key_load[ch] = 1'b1;
    key_in       = k;
    tick();
    key_load = '0;
  endtask

  initial begin
    byte_t        held_c;
    logic [CW-1:0] held_ch;
    int           nxt;

    for (int x = 0; x < 256; x++) sbox_ref[x] = sbox_math(byte_t'(x));

    rst        = 1'b1;
    key_load   = '0;
    key_in     = 8'h00;
    req_valid  = '0;
    req_char   = '0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic path: key 0x00 on ch0, two bytes 0x41.
    load_key(0, 8'h00);
    req_valid[0]  = 1'b1;
    req_char[7:0] = 8'h41;
    @(negedge clk); check("basic_grant0", req_ready, 4'b0001);
    tick();
    @(negedge clk); check("basic_latency_empty", dout_valid, 1'b0);
                    check("basic_grant1", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk); check("basic_v0", dout_valid, 1'b1);
                    check("basic_c0", dout_char, 8'h22);
                    check("basic_ch0", dout_chan, 2'd0);
    @(negedge clk); check("basic_c1", dout_char, 8'h3d);
    @(negedge clk); check("basic_drained", dout_valid, 1'b0);

    // Counter wrap on ch1.
    seen.delete();
    load_key(1, 8'hFF);
    req_valid[1]   = 1'b1;
    req_char[15:8] = 8'h00;
    repeat (2) tick();
    req_valid = '0;
    repeat (4) tick();
    check("wrap_count", seen.size(), 2);
    if (seen.size() >= 2) begin
      check("wrap_c0", seen[0].c, 8'h16);
      check("wrap_c1", seen[1].c, 8'h63);
      check("wrap_ch", seen[1].ch, 1);
    end

    // key_load and request on ch0 in the same cycle.
    seen.delete();
    key_load      = 4'b0001;
    key_in        = 8'h53;
    req_valid     = 4'b0001;
    req_char[7:0] = 8'h00;
    @(negedge clk); check("loadwin_no_grant", req_ready, 4'b0000);
    tick();
    key_load = '0;
    @(negedge clk); check("loadwin_grant_next", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();
    check("loadwin_count", seen.size(), 1);
    if (seen.size() >= 1) check("loadwin_c", seen[0].c, 8'hed);

    // Unkeyed ch2 requesting: never granted; others rotate 0,1,3.
    load_key(3, 8'h10);
    grant_log.delete();
    req_valid = 4'hF;
    for (int r = 0; r < 12; r++) begin
      req_char = $urandom;
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    check("unkeyed_grants", grant_log.size(), 12);
    for (int k = 0; k + 1 < grant_log.size(); k++) begin
      nxt = (grant_log[k] + 1) % N;
      if (nxt == 2) nxt = 3;
      check("unkeyed_order", grant_log[k + 1], nxt);
    end

    // Fairness with all four keyed.
    load_key(2, 8'h80);
    grant_log.delete();
    seen.delete();
    req_valid = 4'hF;
    for (int r = 0; r < 16; r++) begin
      req_char = $urandom;
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    check("fair_grants", grant_log.size(), 16);
    check("fair_seen", seen.size(), grant_log.size());
    for (int k = 0; k + 1 < grant_log.size(); k++) begin
      check("fair_order", grant_log[k + 1], (grant_log[k] + 1) % N);
    end
    for (int k = 0; k < seen.size() && k < grant_log.size(); k++) begin
      check("fair_dout_chan_order", seen[k].ch, grant_log[k]);
    end

    // Backpressure: 3 stalled cycles with the pipe full.
    grant_log.delete();
    seen.delete();
    req_valid = 4'hF;
    repeat (3) begin
      req_char = $urandom;
      tick();
    end
    dout_ready = 1'b0;
    held_c     = dout_char;
    held_ch    = dout_chan;
    repeat (3) begin
      @(negedge clk);
      check("bp_req_ready_zero", req_ready, 4'b0000);
      check("bp_valid_held", dout_valid, 1'b1);
      check("bp_char_held", dout_char, held_c);
      check("bp_chan_held", dout_chan, held_ch);
      tick();
    end
    dout_ready = 1'b1;
    repeat (4) tick();
    req_valid = '0;
    repeat (4) tick();
    check("bp_no_loss_dup", seen.size(), grant_log.size());

    // Reset with bytes in flight.
    req_valid = 4'hF;
    repeat (3) tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_dout_valid", dout_valid, 1'b0);
    check("midrst_dout_char", dout_char, 8'h00);
    check("midrst_req_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("postrst_unkeyed_ignored", req_ready, 4'b0000);
    end
    req_valid = '0;

    // Randomized traffic with random rekeys and sink stalls.
    key_load = 4'hF;
    key_in   = byte_t'($urandom);
    tick();
    key_load = '0;
    grant_log.delete();
    seen.delete();
    for (int r = 0; r < 2000; r++) begin
      for (int i = 0; i < N; i++) key_load[i] = ($urandom_range(0, 31) == 0);
      key_in     = byte_t'($urandom);
      req_valid  = N'($urandom);
      req_char   = $urandom;
      dout_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    key_load   = '0;
    req_valid  = '0;
    dout_ready = 1'b1;
    repeat (5) tick();
    check("rand_no_loss_dup", seen.size(), grant_log.size());
    check("rand_drained", dout_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sbox_cipher_channel_arbiter
